// File: rtl/narrow_16to10.sv
//==============================================================================
// Module      : narrow_16to10
// Description : Registered 16-to-10-bit two's-complement narrowing stage with
//               valid/ready handshake, overflow flag and overflow statistics.
//               NARROW_SAT_EN selects saturation; otherwise overflow wraps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module narrow_16to10 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             ovf_clr
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int c_HI_W = IN_W - OUT_W + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [OUT_W-1:0]   r_data;
  logic               r_ovf;
  logic               r_ovf_sticky;
  logic [CNT_W-1:0]   r_ovf_count;

  logic               w_accept;
  logic [c_HI_W-1:0]  w_hi;
  logic               w_fits;
  logic               w_ovf_event;
  logic [OUT_W-1:0]   w_result;

  assign out_valid   = (r_state == ST_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;

  // The word fits when the sign bit plus every discarded bit agree.
  assign w_hi        = data_in[IN_W-1:OUT_W-1];
  assign w_fits      = (&w_hi) || !(|w_hi);
  assign w_ovf_event = w_accept && !w_fits;

`ifdef NARROW_SAT_EN
  localparam logic [OUT_W-1:0] c_SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_result = data_in[OUT_W-1:0];
    if (!w_fits) begin
      w_result = data_in[IN_W-1] ? c_SAT_NEG : c_SAT_POS;
    end
  end
`else
  always_comb begin
    w_result = data_in[OUT_W-1:0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (!w_accept && out_ready) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_result;
      r_ovf  <= !w_fits;
    end
  end

  // A clear coinciding with an overflow lands as the first event after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else if (ovf_clr) begin
      r_ovf_sticky <= w_ovf_event;
      r_ovf_count  <= w_ovf_event ? CNT_W'(1) : '0;
    end else if (w_ovf_event) begin
      r_ovf_sticky <= 1'b1;
      if (!(&r_ovf_count)) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

  assign data_out   = r_data;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule

`default_nettype wire

// File: doc/narrow_16to10.md
Name: narrow_16to10

Overview:
Registered narrowing unit, the inverse of the 10-to-16-bit sign-extension path. It converts a 16-bit two's-complement word back to a 10-bit two's-complement field for the 10-bit immediate/operand datapath. Overflow detection, optional saturation, valid/ready handshaking on both sides, and overflow statistics are included. It sits between the 16-bit ALU result bus and any consumer that stores or transmits 10-bit fields.

Parameters:
IN_W, 16, input word width (two's complement)
OUT_W, 10, output field width (two's complement); OUT_W < IN_W
CNT_W, 8, width of the overflow event counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  data_in is valid this cycle
in_ready  output  1  block accepts data_in this cycle
data_in  input  IN_W  16-bit signed value to narrow
out_valid  output  1  data_out holds a valid result
out_ready  input  1  consumer accepts data_out this cycle
data_out  output  OUT_W  narrowed 10-bit signed value
ovf  output  1  result currently held on data_out overflowed the 10-bit range
ovf_sticky  output  1  set on any accepted overflowing word; cleared only by ovf_clr or rst
ovf_count  output  CNT_W  number of accepted overflowing words; saturates at all-ones
ovf_clr  input  1  synchronous clear of ovf_sticky and ovf_count

Behaviour:
- Reset (async, rst=1): out_valid=0, data_out=0, ovf=0, ovf_sticky=0, ovf_count=0. in_ready reads 1 once rst deasserts. Mid-transfer reset discards the held word; no partial output.
- Two-state control: EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational). Pass-through at full throughput is allowed.
- Accept = in_valid && in_ready. On accept, the output register loads on the same clk edge. Latency is 1 cycle; out_valid=1 in the next cycle.
- EMPTY -> FULL on accept.
- FULL -> EMPTY when out_ready=1 and there is no accept.
- FULL stays FULL when out_ready=1 with an accept (new word replaces old).
- FULL with out_ready=0: data_out and ovf are held stable, and in_ready=0.
- Range check: data_in fits iff bits [IN_W-1:OUT_W-1] (bits 15..9) are all equal. Sign is bit 15; output sign is bit 9. Valid output range is -512..+511.
- Overflow: ovf_next = !fits. ovf is registered alongside data_out.
- Result when fits: data_in[OUT_W-1:0].
- Result when not fits: see Optional Feature.
- Statistics update only on accept with ovf_next=1: ovf_sticky<=1, and ovf_count<=ovf_count+1, saturating at 2^CNT_W-1 (no wrap).
- ovf_clr=1 clears both. If ovf_clr coincides with an accepted overflow, the clear is applied first, then the event: ovf_sticky=1, ovf_count=1.
- in_valid=0 has no effect on statistics. data_in is ignored when not accepted.

Optional Feature:
Macro NARROW_SAT_EN.
- Defined: overflowing inputs saturate. Positive overflow (data_in[15]=0) gives 10'h1FF (+511); negative overflow (data_in[15]=1) gives 10'h200 (-512).
- Undefined: overflowing inputs wrap, giving data_in[9:0] (plain truncation).
- ovf, ovf_sticky and ovf_count behave identically in both builds.

Test Plan:
1. Reset, then stream data_in=16'hFF00 (-256) with out_ready=1 -> next cycle out_valid=1, data_out=10'h300, ovf=0, ovf_count=0.
2. data_in=16'h01FF (+511), then 16'hFE00 (-512) -> data_out=10'h1FF then 10'h200, both ovf=0 (boundary values fit).
3. data_in=16'h0200 (+512), then 16'h8000 -> with NARROW_SAT_EN: 10'h1FF, 10'h200. Without it: 10'h200, 10'h000. Both builds: ovf=1 each, ovf_count=2, ovf_sticky=1.
4. Backpressure: accept 16'h0005, hold out_ready=0 for 3 cycles while in_valid=1 with 16'h0007 -> in_ready=0, data_out stays 10'h005. Raise out_ready -> 10'h005 consumed, 10'h007 appears next cycle; no word lost or duplicated.
5. Feed 300 overflowing words (16'h7FFF) with CNT_W=8 -> ovf_count stops at 8'hFF. Assert ovf_clr in the same cycle as another overflowing accept -> ovf_count=1, ovf_sticky=1.
6. Assert rst asynchronously mid-cycle while FULL with out_ready=0 -> out_valid, data_out, ovf, ovf_sticky, ovf_count all 0 immediately. After release, in_ready=1.
